// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes common with the main control decoder,
// the encoder's instruction-kind enum and its FSM state enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Encodings 6 and 7 are deliberately unnamed: they are the illegal kinds.
  typedef enum logic [2:0] {
    KIND_RTYPE = 3'd0,
    KIND_LW    = 3'd1,
    KIND_SW    = 3'd2,
    KIND_BEQ   = 3'd3,
    KIND_ADDI  = 3'd4,
    KIND_J     = 3'd5
  } instr_kind_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_PAD   = 2'd2,
    S_FULL  = 2'd3
  } enc_state_e;

  function automatic logic is_branch(input logic [2:0] kind);
    return (kind == KIND_BEQ) || (kind == KIND_J);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: instruction kind plus register/immediate fields
// into a 32-bit MIPS word, with a flag for illegal kinds.
module instr_field_pack
  import mips_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [25:0] imm,
  output logic        legal,
  output logic [31:0] word
);

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves an output
    // unassigned and infers a latch.
    legal = 1'b1;
    word  = '0;
    case (kind)
      KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_LW:    word = {OP_LW,   rs, rt, imm[15:0]};
      KIND_SW:    word = {OP_SW,   rs, rt, imm[15:0]};
      KIND_BEQ:   word = {OP_BEQ,  rs, rt, imm[15:0]};
      KIND_ADDI:  word = {OP_ADDI, rs, rt, imm[15:0]};
      KIND_J:     word = {OP_J,    imm};
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: packs one request per handshake and
// writes it to instruction memory. Define INSTR_ENC_DELAY_SLOT_EN to pad BEQ/J with a NOP.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int              ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [25:0]       in_imm,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              full
);

  enc_state_e  state, state_next;
  logic        legal;
  logic [31:0] word;
  logic        accept, ack_fire, restart, addr_last, start_pend, pad_due;

  instr_field_pack u_pack (
    .kind  (in_kind),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .shamt (in_shamt),
    .funct (in_funct),
    .imm   (in_imm),
    .legal (legal),
    .word  (word)
  );

  assign addr_last = (mem_addr == {ADDR_W{1'b1}});
  // A same-cycle start wins over the request, so the request must not see ready.
  assign in_ready  = (state == S_IDLE) && !reset && !start;
  assign mem_we    = (state == S_WRITE) || (state == S_PAD);

`ifdef INSTR_ENC_DELAY_SLOT_EN
  logic branch_q;

  always_ff @(posedge clk) begin
    if (reset)       branch_q <= 1'b0;
    else if (accept) branch_q <= is_branch(in_kind);
  end

  assign pad_due = (state == S_WRITE) && branch_q && !addr_last;
`else
  assign pad_due = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) so every register samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ack_fire   = 1'b0;
    restart    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          restart = 1'b1;
        end else if (in_valid) begin
          accept = 1'b1;
          if (legal) state_next = S_WRITE;
        end
      end
      S_WRITE, S_PAD: begin
        if (mem_ack) begin
          ack_fire = 1'b1;
          if (pad_due)                  state_next = S_PAD;
          else if (start || start_pend) restart    = 1'b1;
          else if (addr_last)           state_next = S_FULL;
          else                          state_next = S_IDLE;
        end
      end
      S_FULL:  if (start) restart = 1'b1;
      default: state_next = S_IDLE;
    endcase
    if (restart) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      count      <= '0;
      err        <= 1'b0;
      full       <= 1'b0;
      start_pend <= 1'b0;
    end else if (restart) begin
      mem_addr   <= BASE_ADDR;
      count      <= '0;
      err        <= 1'b0;
      full       <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      if (accept) begin
        if (legal) mem_wdata <= word;
        else       err       <= 1'b1;
      end
      if (mem_we && start) start_pend <= 1'b1;
      if (ack_fire) begin
        count <= count + 1'b1;
        // The last address is kept in FULL rather than wrapping to zero.
        if (state_next == S_FULL) full     <= 1'b1;
        else                      mem_addr <= mem_addr + 1'b1;
        if (pad_due) mem_wdata <= '0;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and program loader: the write-side counterpart of the main control decoder. It accepts one instruction per valid/ready handshake as an instruction class plus register and immediate fields, and packs it into a 32-bit MIPS word. It writes that word into instruction memory at an auto-incrementing word address. It sits between the test/boot program source and the instruction memory of the single-cycle CPU.

## Interface
- ADDR_W, 6: instruction-memory word-address width
- BASE_ADDR, 0: first word address written after reset or `start`
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept
- in_kind  in  3  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6–7 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_shamt  in  5  R-type shift amount
- in_funct  in  6  R-type function code
- in_imm  in  26  [15:0] for I-types, [25:0] for J
- start  in  1  restart program: address to BASE_ADDR, counters and flags cleared
- mem_we  out  1  write strobe, held until acked
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ack  in  1  memory accepted the write this cycle
- count  out  ADDR_W+1  words written since reset/start
- err  out  1  sticky: an illegal in_kind was accepted
- full  out  1  last address written; no further accepts

## Operation
- Encodings:
  - RTYPE {000000,rs,rt,rd,shamt,funct}.
  - LW {100011,rs,rt,imm[15:0]}.
  - SW {101011,…}.
  - BEQ {000100,…}.
  - ADDI {001000,…}.
  - J {000010,imm[25:0]}.
  - Unused input bits are ignored.
- FSM states IDLE, WRITE, FULL (plus PAD, see Configuration).
- IDLE: in_ready=1. Accept on in_valid&in_ready.
  - Legal kind: register the word into mem_wdata and enter WRITE.
  - Illegal kind: consumed, nothing written, err set, stay IDLE.
- WRITE: mem_we=1, addr/wdata stable, in_ready=0. On mem_ack:
  - count+1.
  - If mem_addr == 2^ADDR_W−1 → FULL (address not incremented, no wrap).
  - Else mem_addr+1 → IDLE.
- FULL: in_ready=0, full=1. Only `start` or reset leaves it.
- `start` in IDLE/FULL: mem_addr=BASE_ADDR, count=0, err=0, full=0 → IDLE. It takes priority over a same-cycle accept; that request is not consumed.
- `start` in WRITE/PAD is latched as pending, applied in the cycle after the final ack, and the write completes first.
- Reset mid-write abandons the write immediately (mem_we=0 next cycle).

## Timing
- Reset values: mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, count 0, err 0, full 0, state IDLE. in_ready is 0 while reset is high and 1 in the cycle after.
- Accept at edge N → mem_we=1 during cycle N+1.
- mem_ack in that cycle → in_ready=1 in cycle N+2. Peak throughput is one word per 2 cycles.
- Stalls: mem_ack low holds all outputs unchanged indefinitely.
- mem_ack while mem_we=0 is ignored.
- err and full are registered and update the cycle after the causing event.

## Configuration
- INSTR_ENC_DELAY_SLOT_EN defined:
  - After an acked BEQ or J write, the FSM enters PAD.
  - PAD writes 0x00000000 (NOP) at the next address with the same mem_ack handshake and count+1. in_ready=0 throughout.
  - If the branch occupied the last address → FULL; the pad is dropped.
- Undefined: no PAD state. BEQ and J are handled as any other kind.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J (common with the decoder);
  - the instruction-kind enum;
  - the FSM state enum.
- Sub-module instr_field_pack: purely combinational kind+fields → {legal, word[31:0]}. The top holds the FSM, address/count registers and the handshake.

## Test plan
- Reset, then ADDI rs=0 rt=8 imm=5 with mem_ack tied 1 → mem_wdata 0x20080005 at addr 0, count=1, in_ready back high 2 cycles after accept.
- Stream LW rs0 rt2 imm 0x10, RTYPE rs1 rt2 rd3 funct 0x20, SW → words 0x8C020010, 0x00221820, 0xAC... at addrs 0,1,2. Hold mem_ack low 3 cycles on the second write → outputs stable, no accept.
- in_kind=7 → no mem_we, err=1, count unchanged. The next legal request still writes at the unchanged address.
- ADDR_W=2: five requests → four written, full=1 after the 4th ack, 5th never accepted. `start` → full=0, mem_addr=0, count=0.
- With INSTR_ENC_DELAY_SLOT_EN: BEQ rs1 rt2 imm 0xFFFF then J imm 0x10 → 0x1022FFFF, 0x00000000, 0x08000010, 0x00000000 at addrs 0–3, count=4. Without the macro: two words only.
- Reset asserted during WRITE with mem_ack low → mem_we=0 and all outputs at reset values the next cycle.
